// File: rtl/clk_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// clk_ctrl_pkg
// Types shared by the CPU clock-source controller.
//   clk_state_t : FSM state of cpu_clock_ctrl.
//     STEP_IDLE - single-step mode, cpu_clk low, waiting for a button press
//     STEP_HI   - single-step high phase, one CPU clock pulse in progress
//     RUN_LO    - free-run low phase
//     RUN_HI    - free-run high phase
// -----------------------------------------------------------------------------
package clk_ctrl_pkg;

  typedef enum logic [1:0] {
    STEP_IDLE = 2'd0,
    STEP_HI   = 2'd1,
    RUN_LO    = 2'd2,
    RUN_HI    = 2'd3
  } clk_state_t;

endpackage : clk_ctrl_pkg

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// Synchronizes an asynchronous push-button and accepts a new level only once
// it has held, on the synchronized signal, for CYCLES consecutive clk cycles.
// A registered one-cycle pulse marks each accepted 0->1 transition.
//
// Parameters
//   CYCLES : cycles a new synchronized level must persist before acceptance (>= 2)
// Ports
//   clk    in  : board clock
//   reset  in  : asynchronous, active-high reset
//   btn    in  : raw asynchronous button, active-high
//   level  out : debounced (stable) button level
//   press  out : one-cycle pulse, one cycle after level rises
//
// Latency: a button level sampled on edge E0 reaches the synchronized output
// at E1, is accepted into level at E1+CYCLES, and pulses press at E2+CYCLES.
// -----------------------------------------------------------------------------
module button_debouncer #(
  parameter int CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int             CW       = $clog2(CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic          stable_q, stable_d;
  logic          stable_dly_q;
  logic          press_q;

  // The counter only runs while the synchronized input disagrees with the
  // accepted level; any agreement (a bounce back) restarts the qualification.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned, which would otherwise infer a latch.
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      cnt_q        <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of the others, making the two-stage
      // synchronizer a real two-stage chain rather than a single wire.
      sync1_q      <= btn;
      sync2_q      <= sync1_q;
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      press_q      <= stable_q & ~stable_dly_q;
    end
  end

  assign level = stable_q;
  assign press = press_q;

endmodule : button_debouncer

// File: rtl/cpu_clock_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_clock_ctrl
// CPU clock source for the TD4 board. Produces cpu_clk either free-running
// (RATIO board cycles per CPU period, 50% duty) or one pulse per debounced
// step-button press. Mode changes take effect only at phase boundaries, so a
// high phase is never shortened and the CPU never sees a runt pulse.
//
// Parameters
//   RATIO           : board cycles per CPU clock period (even, >= 2)
//   DEBOUNCE_CYCLES : step-button debounce qualification time (>= 2)
// Ports
//   clk      in  : board clock
//   reset    in  : asynchronous, active-high reset
//   run_mode in  : async switch, 1 = free-run, 0 = single-step
//   step_btn in  : async push-button, active-high
//   cpu_clk  out : registered CPU clock
//   cpu_tick out : registered pulse in the first clk cycle cpu_clk is high
//   running  out : registered, high while in RUN_LO / RUN_HI
// -----------------------------------------------------------------------------
module cpu_clock_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int RATIO           = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic run_mode,
  input  logic step_btn,
  output logic cpu_clk,
  output logic cpu_tick,
  output logic running
);

  localparam int            HALF     = RATIO / 2;
  // RATIO = 2 gives single-cycle phases; keep the counter at least one bit.
  localparam int            CW       = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);

  logic          run_meta_q;
  logic          run_sync_q;
  logic          press;
  logic          unused_btn_level;   // debounced level, kept for debug probing

  clk_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          phase_end;
  logic          cpu_clk_q, cpu_tick_q, running_q;
  logic          hi_d, hi_q;

  button_debouncer #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_step_debounce (
    .clk   (clk),
    .reset (reset),
    .btn   (step_btn),
    .level (unused_btn_level),
    .press (press)
  );

  assign phase_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      // Run mode outranks a coincident press; that press is simply lost.
      STEP_IDLE: begin
        if (run_sync_q)  state_d = RUN_LO;
        else if (press)  state_d = STEP_HI;
      end
      STEP_HI: begin
        if (phase_end)   state_d = run_sync_q ? RUN_LO : STEP_IDLE;
      end
      // A low phase may be abandoned at once: cpu_clk is already low, so
      // leaving early cannot produce a runt pulse.
      RUN_LO: begin
        if (!run_sync_q) state_d = STEP_IDLE;
        else if (phase_end) state_d = RUN_HI;
      end
      RUN_HI: begin
        if (phase_end)   state_d = run_sync_q ? RUN_LO : STEP_IDLE;
      end
      default:           state_d = STEP_IDLE;
    endcase
  end

  // Every timed state exits on phase_end, so a state change is the only
  // place the counter needs to restart; STEP_IDLE holds it at zero.
  always_comb begin
    if (state_d != state_q || state_q == STEP_IDLE) cnt_d = '0;
    else                                           cnt_d = cnt_q + 1'b1;
  end

  assign hi_q = (state_q == STEP_HI) || (state_q == RUN_HI);
  assign hi_d = (state_d == STEP_HI) || (state_d == RUN_HI);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_meta_q <= 1'b0;
      run_sync_q <= 1'b0;
      state_q    <= STEP_IDLE;
      cnt_q      <= '0;
      cpu_clk_q  <= 1'b0;
      cpu_tick_q <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      run_meta_q <= run_mode;
      run_sync_q <= run_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      // Outputs decode the next state so they switch on the same edge as
      // the state register, glitch-free and without an extra cycle of lag.
      cpu_clk_q  <= hi_d;
      cpu_tick_q <= hi_d & ~hi_q;
      running_q  <= (state_d == RUN_LO) || (state_d == RUN_HI);
    end
  end

  assign cpu_clk  = cpu_clk_q;
  assign cpu_tick = cpu_tick_q;
  assign running  = running_q;

endmodule : cpu_clock_ctrl

// File: tb/tb_cpu_clock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_clock_ctrl
// Directed bench for cpu_clock_ctrl with RATIO=8, DEBOUNCE_CYCLES=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Within each scenario, "Ek" is the k-th rising edge after the stimulus that
// starts it, and sample k is taken on the falling edge just after Ek.
// Expected timing (hand derived):
//   free-run : run_mode seen at E2 -> RUN_LO, first rise at E6, then 4/4.
//   step     : button sampled at E0 -> press after E6 -> cpu_clk high E7..E10.
// -----------------------------------------------------------------------------
module tb_cpu_clock_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic run_mode;
  logic step_btn;
  logic cpu_clk;
  logic cpu_tick;
  logic running;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_clock_ctrl #(
    .RATIO           (8),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .run_mode (run_mode),
    .step_btn (step_btn),
    .cpu_clk  (cpu_clk),
    .cpu_tick (cpu_tick),
    .running  (running)
  );

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    run_mode = 1'b0;
    step_btn = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // Reset holds everything low even with both inputs asserted.
  task automatic test_reset();
    reset    = 1'b1;
    run_mode = 1'b1;
    step_btn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      total++;
      if (cpu_clk !== 1'b0) begin
        bad++; $display("FAIL reset_clk k=%0d got=%b exp=0", k, cpu_clk);
      end
      total++;
      if (cpu_tick !== 1'b0) begin
        bad++; $display("FAIL reset_tick k=%0d got=%b exp=0", k, cpu_tick);
      end
      total++;
      if (running !== 1'b0) begin
        bad++; $display("FAIL reset_running k=%0d got=%b exp=0", k, running);
      end
    end
  endtask

  task automatic test_free_run();
    logic e_clk, e_tick, e_run;
    int   m;
    do_reset();
    run_mode = 1'b1;
    for (int k = 0; k < 26; k++) begin
      cycle();
      if (k < 2) begin
        e_clk = 1'b0; e_tick = 1'b0; e_run = 1'b0;
      end else begin
        m      = k - 2;
        e_clk  = ((m / 4) % 2) == 1;
        e_tick = (m % 8) == 4;
        e_run  = 1'b1;
      end
      total++;
      if (cpu_clk !== e_clk) begin
        bad++; $display("FAIL free_clk k=%0d got=%b exp=%b", k, cpu_clk, e_clk);
      end
      total++;
      if (cpu_tick !== e_tick) begin
        bad++; $display("FAIL free_tick k=%0d got=%b exp=%b", k, cpu_tick, e_tick);
      end
      total++;
      if (running !== e_run) begin
        bad++; $display("FAIL free_running k=%0d got=%b exp=%b", k, running, e_run);
      end
    end
  endtask

  task automatic test_step_clean();
    logic e_clk, e_tick;
    int   ticks = 0;
    do_reset();
    step_btn = 1'b1;
    for (int k = 0; k < 24; k++) begin
      cycle();
      if (k == 9) step_btn = 1'b0;   // held for E0..E9
      e_clk  = (k >= 7) && (k <= 10);
      e_tick = (k == 7);
      if (cpu_tick === 1'b1) ticks++;
      total++;
      if (cpu_clk !== e_clk) begin
        bad++; $display("FAIL step_clk k=%0d got=%b exp=%b", k, cpu_clk, e_clk);
      end
      total++;
      if (cpu_tick !== e_tick) begin
        bad++; $display("FAIL step_tick k=%0d got=%b exp=%b", k, cpu_tick, e_tick);
      end
      total++;
      if (running !== 1'b0) begin
        bad++; $display("FAIL step_running k=%0d got=%b exp=0", k, running);
      end
    end
    total++;
    if (ticks != 1) begin
      bad++; $display("FAIL step_tick_count got=%0d exp=1", ticks);
    end
  endtask

  // Button samples 1,0,1,0 on E0..E3, then 1 from E4: the last rising level
  // lands at E4, so the single pulse is E11..E14. A one-cycle dip at E13
  // (inside the high phase) must not create another pulse.
  task automatic test_bounce();
    logic e_clk;
    int   rises = 0;
    logic prev  = 1'b0;
    do_reset();
    step_btn = 1'b1;
    for (int k = 0; k < 34; k++) begin
      cycle();
      case (k)
        0:  step_btn = 1'b0;
        1:  step_btn = 1'b1;
        2:  step_btn = 1'b0;
        3:  step_btn = 1'b1;
        12: step_btn = 1'b0;
        13: step_btn = 1'b1;
        24: step_btn = 1'b0;
        default: ;
      endcase
      e_clk = (k >= 11) && (k <= 14);
      if (cpu_clk === 1'b1 && prev === 1'b0) rises++;
      prev = cpu_clk;
      total++;
      if (cpu_clk !== e_clk) begin
        bad++; $display("FAIL bounce_clk k=%0d got=%b exp=%b", k, cpu_clk, e_clk);
      end
    end
    total++;
    if (rises != 1) begin
      bad++; $display("FAIL bounce_pulse_count got=%0d exp=1", rises);
    end
  endtask

  // run_mode drops after E5 so run_sync is 0 while RUN_HI has cnt=1; the
  // high phase E6..E9 still completes, then STEP_IDLE from E10.
  task automatic test_run_drop();
    logic e_clk, e_tick, e_run;
    do_reset();
    run_mode = 1'b1;
    for (int k = 0; k < 25; k++) begin
      cycle();
      if (k == 5) run_mode = 1'b0;
      e_clk  = (k >= 6) && (k <= 9);
      e_tick = (k == 6);
      e_run  = (k >= 2) && (k <= 9);
      total++;
      if (cpu_clk !== e_clk) begin
        bad++; $display("FAIL drop_clk k=%0d got=%b exp=%b", k, cpu_clk, e_clk);
      end
      total++;
      if (cpu_tick !== e_tick) begin
        bad++; $display("FAIL drop_tick k=%0d got=%b exp=%b", k, cpu_tick, e_tick);
      end
      total++;
      if (running !== e_run) begin
        bad++; $display("FAIL drop_running k=%0d got=%b exp=%b", k, running, e_run);
      end
    end
  endtask

  // press is high after E6; run_mode set after E4 gives run_sync high after
  // E6 too. Both are seen at E7: RUN_LO E7..E10, first rise at E11.
  task automatic test_run_and_press();
    logic e_clk, e_tick, e_run;
    do_reset();
    step_btn = 1'b1;
    for (int k = 0; k < 23; k++) begin
      cycle();
      if (k == 4)  run_mode = 1'b1;
      if (k == 12) step_btn = 1'b0;
      e_clk  = (k >= 11) && (((k - 11) / 4) % 2 == 0);
      e_tick = (k >= 11) && ((k - 11) % 8 == 0);
      e_run  = (k >= 7);
      total++;
      if (cpu_clk !== e_clk) begin
        bad++; $display("FAIL both_clk k=%0d got=%b exp=%b", k, cpu_clk, e_clk);
      end
      total++;
      if (cpu_tick !== e_tick) begin
        bad++; $display("FAIL both_tick k=%0d got=%b exp=%b", k, cpu_tick, e_tick);
      end
      total++;
      if (running !== e_run) begin
        bad++; $display("FAIL both_running k=%0d got=%b exp=%b", k, running, e_run);
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic e_clk, e_tick;
    do_reset();
    step_btn = 1'b1;
    repeat (8) @(posedge clk);       // E0..E7; STEP_HI entered at E7
    #1;
    total++;
    if (cpu_clk !== 1'b1 || cpu_tick !== 1'b1) begin
      bad++; $display("FAIL mid_pre_reset clk=%b tick=%b exp=1,1", cpu_clk, cpu_tick);
    end
    step_btn = 1'b0;
    reset    = 1'b1;
    #1;                              // still well before the next clk edge
    total++;
    if (cpu_clk !== 1'b0) begin
      bad++; $display("FAIL mid_async_clk got=%b exp=0", cpu_clk);
    end
    total++;
    if (cpu_tick !== 1'b0) begin
      bad++; $display("FAIL mid_async_tick got=%b exp=0", cpu_tick);
    end
    total++;
    if (running !== 1'b0) begin
      bad++; $display("FAIL mid_async_running got=%b exp=0", running);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 15; k++) begin
      cycle();
      total++;
      if (cpu_clk !== 1'b0 || running !== 1'b0) begin
        bad++; $display("FAIL mid_idle k=%0d clk=%b running=%b exp=0,0", k, cpu_clk, running);
      end
    end
    step_btn = 1'b1;
    for (int k = 0; k < 13; k++) begin
      cycle();
      e_clk  = (k >= 7) && (k <= 10);
      e_tick = (k == 7);
      total++;
      if (cpu_clk !== e_clk) begin
        bad++; $display("FAIL mid_repress_clk k=%0d got=%b exp=%b", k, cpu_clk, e_clk);
      end
      total++;
      if (cpu_tick !== e_tick) begin
        bad++; $display("FAIL mid_repress_tick k=%0d got=%b exp=%b", k, cpu_tick, e_tick);
      end
    end
    step_btn = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    run_mode = 1'b0;
    step_btn = 1'b0;
    #1;
    test_reset();
    test_free_run();
    test_step_clean();
    test_bounce();
    test_run_drop();
    test_run_and_press();
    test_reset_mid_pulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cpu_clock_ctrl

// File: doc/cpu_clock_ctrl.md
# cpu_clock_ctrl

Clock-source controller sitting directly upstream of the TD4 mother board: it produces the CPU clock that drives `ctrl_bus.clk` and replaces the bare free-running prescaler. It runs either free-running (divided from the board clock) or single-step (one CPU clock pulse per debounced push-button press). Mode changes only take effect at phase boundaries, so the CPU never sees a runt pulse.

## Interface
- `RATIO`, 100_000_000: board-clock cycles per CPU clock period; even, ≥ 2; each phase lasts `RATIO/2` cycles.
- `DEBOUNCE_CYCLES`, 1_000_000: cycles the synchronized button must hold a new level before it is accepted; ≥ 2.

- `clk`  in  1  board clock (CLOCK_50 at top level).
- `reset`  in  1  asynchronous, active-high reset.
- `run_mode`  in  1  asynchronous switch; 1 = free-run, 0 = single-step.
- `step_btn`  in  1  asynchronous push-button, active-high (top inverts the board's active-low KEY).
- `cpu_clk`  out  1  registered CPU clock to `ctrl_bus.clk`.
- `cpu_tick`  out  1  registered one-cycle pulse, high in the first `clk` cycle that `cpu_clk` is high.
- `running`  out  1  registered; 1 while in RUN_LO/RUN_HI.

## Operation
- Single clock `clk`. Reset is asynchronous and active-high.
- `run_mode` passes through a 2-flop synchronizer (`run_sync`).
- `step_btn` passes through a 2-flop synchronizer, then the debouncer. Debounce counter clears whenever the synchronized level equals the stable level. When they differ for `DEBOUNCE_CYCLES` consecutive cycles, the stable level takes the new value. `press` is a one-cycle pulse on a stable 0→1 edge.
- Phase counter `cnt`, width `$clog2(RATIO/2)`, counts 0..RATIO/2-1. It clears on every state change.
- FSM states:
  - STEP_IDLE (`cpu_clk`=0)
    - `run_sync` → RUN_LO.
    - else `press` → STEP_HI.
    - If both are present, run wins and the press is dropped.
  - STEP_HI (`cpu_clk`=1)
    - At `cnt`=RATIO/2-1 → RUN_LO if `run_sync`, else STEP_IDLE.
    - Presses during STEP_HI are dropped.
  - RUN_LO (`cpu_clk`=0)
    - `!run_sync` → STEP_IDLE immediately.
    - else at `cnt`=RATIO/2-1 → RUN_HI.
  - RUN_HI (`cpu_clk`=1)
    - At `cnt`=RATIO/2-1 → RUN_LO if `run_sync`, else STEP_IDLE.
    - A high phase is never truncated.
- `cpu_tick` asserts on every entry into RUN_HI or STEP_HI.

## Timing
- Reset values: state=STEP_IDLE, `cnt`=0, `cpu_clk`=0, `cpu_tick`=0, `running`=0. Synchronizers, debounce counter and stable level are all 0.
- `cpu_clk`, `cpu_tick` and `running` are flops decoded from the next state. Each changes on the same `clk` edge as the state register.
- Free-run: `cpu_clk` is low for exactly RATIO/2 cycles, then high for exactly RATIO/2 cycles, with no jitter.
- Step latency: a button edge reaches `press` 2 + `DEBOUNCE_CYCLES` cycles after it lands on the synchronized input. `cpu_clk` rises on the edge after `press`. It stays high exactly RATIO/2 cycles.
- The button must be released, and the release debounced, before another press is recognised.
- Run-mode latency: 2 sync cycles, plus the wait for the next phase boundary when `cpu_clk` is high.
- `reset` asserted mid-pulse drops `cpu_clk` asynchronously. After release, operation restarts from STEP_IDLE.

## Structure
- Package `clk_ctrl_pkg` holds:
  - `clk_state_t` enum {STEP_IDLE, STEP_HI, RUN_LO, RUN_HI}.
  - No other shared constants; `RATIO` stays a parameter.
- Sub-module `button_debouncer` (parameter `CYCLES`), containing the 2-flop synchronizer, counter, stable level and edge pulse. Outputs: `level`, `press`.
- The `run_mode` synchronizer stays inline.

## Test plan
All scenarios use RATIO=8, DEBOUNCE_CYCLES=4.
- Reset, `run_mode`=1 held: `cpu_clk` stays 0 through the 2 sync cycles and 4 RUN_LO cycles. It then toggles 4 high / 4 low repeatedly. `cpu_tick` is one cycle wide at each rise; `running`=1.
- `run_mode`=0, clean `step_btn` press held 10 cycles: `press` fires 6 cycles after the edge; `cpu_clk` is high for exactly 4 cycles, then 0. Exactly one `cpu_tick`.
- Bouncing press (1,0,1,0 every cycle, then held high): only one `cpu_clk` pulse. A second press inside the high phase produces no extra pulse.
- `run_mode` drops while in RUN_HI at `cnt`=1: `cpu_clk` completes its 4-cycle high phase, then goes to STEP_IDLE. `running`=0, with no further pulses.
- `run_mode` rises in STEP_IDLE on the same cycle as `press`: enters RUN_LO and the press is dropped. The first `cpu_clk` rise comes 4 cycles later.
- `reset` asserted during STEP_HI: `cpu_clk`, `cpu_tick` and `running` are 0 asynchronously. After release the block sits in STEP_IDLE until the next press.
